// File: rtl/mem_arbiter.sv
// Shares one RAM port between the icaches and dcaches of CPUS cores; dcache wins in IDLE, round-robin within each class.
// Grant is registered (request in cycle N drives RAM in N+1); waits stay high until ram_ready completes the owner's access.
module mem_arbiter #(
  parameter int CPUS      = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [32*CPUS-1:0]   iaddr,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [32*CPUS-1:0]   daddr,
  input  logic [32*CPUS-1:0]   dstore,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS-1:0]      dwait,
  output logic [32*CPUS-1:0]   iload,
  output logic [32*CPUS-1:0]   dload,
  output logic                 ram_ren,
  output logic                 ram_wen,
  output logic [31:0]          ram_addr,
  output logic [31:0]          ram_store,
  input  logic [31:0]          ram_load,
  input  logic                 ram_ready
);

  localparam int OW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;

  state_t          state;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   drr;
  logic [OW-1:0]   irr;
  logic [CW-1:0]   cnt;
  logic [CPUS-1:0] dreq;
  logic            own_req;
  logic            done;
  logic            release_now;
  logic [OW-1:0]   nxt;

  // First requester at or after ptr, scanning upward with wrap.
  function automatic logic [OW-1:0] pick(input logic [CPUS-1:0] req, input logic [OW-1:0] ptr);
    logic [OW-1:0] c;
    logic [OW-1:0] sel;
    logic          found;
    c     = ptr;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < CPUS; k++) begin
      if (!found && req[c]) begin
        sel   = c;
        found = 1'b1;
      end
      c = (c == OW'(CPUS - 1)) ? '0 : c + 1'b1;
    end
    return sel;
  endfunction

  assign dreq        = dREN | dWEN;
  assign done        = ram_ready & own_req;
  assign release_now = ~own_req | (ram_ready & (cnt == LAST));
  assign nxt         = (owner == OW'(CPUS - 1)) ? '0 : owner + 1'b1;
  assign iload       = {CPUS{ram_load}};
  assign dload       = {CPUS{ram_load}};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      owner <= '0;
      drr   <= '0;
      irr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|dreq) begin
            state <= DGNT;
            owner <= pick(dreq, drr);
            cnt   <= '0;
          end else if (|iREN) begin
            state <= IGNT;
            owner <= pick(iREN, irr);
            cnt   <= '0;
          end
        end
        default: begin
          if (release_now) begin
            state <= IDLE;
            if (state == DGNT) drr <= nxt;
            else               irr <= nxt;
          end else if (done) begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Strobes follow the owner's live request, so a dropped request releases with no RAM access.
  always_comb begin
    own_req   = 1'b0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    iwait     = '1;
    dwait     = '1;
    case (state)
      DGNT: begin
        own_req      = dreq[owner];
        ram_addr     = daddr[32*int'(owner) +: 32];
        ram_store    = dstore[32*int'(owner) +: 32];
        ram_wen      = dWEN[owner];
        ram_ren      = dREN[owner] & ~dWEN[owner];
        dwait[owner] = ~(ram_ready & own_req);
      end
      IGNT: begin
        own_req      = iREN[owner];
        ram_addr     = iaddr[32*int'(owner) +: 32];
        ram_ren      = iREN[owner];
        iwait[owner] = ~(ram_ready & own_req);
      end
      default: ;
    endcase
  end

endmodule
